// File: rtl/uart_tx.sv
// UART transmitter: one start bit, 8 data bits LSB first, STOP_BITS stop bits,
// with bit timing taken from an external oversample tick (tx_enb).
module uart_tx #(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enb,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned BIT_W = 3;
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] DATA_LAST   = BIT_W'(7);
  localparam logic [BIT_W-1:0] STOP_LAST   = BIT_W'(STOP_BITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_d, tx_busy_d, tx_done_d;
  logic             bit_end_c;

  // Last oversample tick of the current bit period.
  assign bit_end_c = tx_enb && (sample_cnt_q == SAMPLE_LAST);

  // State and output registers; tx comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      sample_cnt_q <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done      <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tx           <= tx_d;
      tx_busy      <= tx_busy_d;
      tx_done      <= tx_done_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tx_d         = tx;
    tx_busy_d    = tx_busy;
    tx_done_d    = 1'b0;

    if ((state_q != IDLE) && tx_enb) begin
      sample_cnt_d = bit_end_c ? '0 : sample_cnt_q + CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        tx_busy_d = 1'b0;
        if (tx_start) begin
          shift_d      = tx_data;
          sample_cnt_d = '0;
          bit_cnt_d    = '0;
          tx_d         = 1'b0;
          tx_busy_d    = 1'b1;
          state_d      = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          tx_d    = shift_q[0];
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_cnt_q != DATA_LAST) begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else begin
            tx_d      = 1'b1;
            bit_cnt_d = '0;
            state_d   = STOP;
          end
        end
      end
      STOP: begin
        // bit_cnt is reused to count stop bits.
        if (bit_end_c) begin
          if (bit_cnt_q == STOP_LAST) begin
            bit_cnt_d = '0;
            tx_busy_d = 1'b0;
            tx_done_d = 1'b1;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line-decoding
// monitor pops and checks them on every tx_done.
module tb_uart_tx;

  typedef struct {
    logic [7:0] data;
    int         len;
    bit         gap;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enb = 1'b0;
  logic       tx_start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  bit         sel = 1'b0;
  bit         stall = 1'b0;
  int         tick_period = 1;
  int         tick_ph = 0;

  logic enb_a, start_a, tx_a, busy_a, done_a;
  logic enb_b, start_b, tx_b, busy_b, done_b;
  logic m_tx, m_busy, m_done, m_enb;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  int   done_cnt = 0;

  assign enb_a   = enb & ~sel;
  assign start_a = tx_start & ~sel;
  assign enb_b   = enb & sel;
  assign start_b = tx_start & sel;
  assign m_tx    = sel ? tx_b : tx_a;
  assign m_busy  = sel ? busy_b : busy_a;
  assign m_done  = sel ? done_b : done_a;
  assign m_enb   = sel ? enb_b : enb_a;

  uart_tx u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .tx_enb   (enb_a),
    .tx_start (start_a),
    .tx_data  (tx_data),
    .tx       (tx_a),
    .tx_busy  (busy_a),
    .tx_done  (done_a)
  );

  uart_tx #(.OVERSAMPLE(8), .STOP_BITS(2)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .tx_enb   (enb_b),
    .tx_start (start_b),
    .tx_data  (tx_data),
    .tx       (tx_b),
    .tx_busy  (busy_b),
    .tx_done  (done_b)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, req, req, $time);
  endtask

  // Oversample tick generator; a stall freezes its phase.
  initial forever begin
    @(posedge clk); #3;
    if (stall) enb = 1'b0;
    else begin
      tick_ph = (tick_ph + 1 >= tick_period) ? 0 : tick_ph + 1;
      enb = (tick_ph == 0);
    end
  end

  // Monitor: decodes the line on ticks, checks against the scoreboard on tx_done.
  initial begin : monitor
    int cyc, tick_n, start_cyc, last_done, os, k;
    bit active, prev_tx, busy_bad, stop_ok;
    logic [11:0] bits;
    exp_t e;
    cyc = 0; tick_n = 0; start_cyc = 0; last_done = -100;
    active = 0; prev_tx = 1; busy_bad = 0; bits = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      os = sel ? 8 : 16;
      if (!rst) begin
        active = 0;
        prev_tx = 1;
        continue;
      end
      if (m_done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          stop_ok = sel ? (bits[10:9] == 2'b11) : bits[9];
          chk(active, "frame_seen", int'(active), 1);
          chk(bits[8:1] == e.data, "data", int'(bits[8:1]), int'(e.data));
          chk(!bits[0] && stop_ok, "framing", int'(bits), int'({stop_ok, 1'b0}));
          if (e.len != 0) chk(cyc - start_cyc == e.len, "frame_len", cyc - start_cyc, e.len);
          if (e.gap) chk(start_cyc - last_done == 1, "gap", start_cyc - last_done, 1);
          chk(!m_busy && !busy_bad, "busy", int'({busy_bad, m_busy}), 0);
        end
        last_done = cyc;
        active = 0;
      end else if (!active) begin
        if (prev_tx && !m_tx) begin
          active = 1; tick_n = 0; start_cyc = cyc; bits = '0; busy_bad = 0;
        end
      end else begin
        if (!m_busy) busy_bad = 1;
        if (m_enb) begin
          tick_n++;
          k = tick_n / os;
          if ((tick_n % os == os / 2) && k < 12) bits[k] = m_tx;
        end
      end
      prev_tx = m_tx;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  // Make the next clk edge coincide with a tick so frame lengths are exact.
  task automatic align();
    int n;
    n = 0;
    while (tick_ph != tick_period - 1 && n < 64) begin step(); n++; end
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!m_done && n < budget) begin step(); n++; end
    if (!m_done) chk(1'b0, "done_timeout", n, budget);
  endtask

  task automatic push(input logic [7:0] d, input int len, input bit gap);
    exp_t e;
    e.data = d; e.len = len; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input int len);
    align();
    push(d, len, 1'b0);
    tx_data = d;
    tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    wait_done(6000);
    step();
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2ms");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] vec [4];
    vec[0] = 8'h00; vec[1] = 8'hFF; vec[2] = 8'h55; vec[3] = 8'h80;

    repeat (3) step();
    chk(tx_a == 1'b1, "reset_tx", int'(tx_a), 1);
    chk(busy_a == 1'b0, "reset_busy", int'(busy_a), 0);
    chk(done_a == 1'b0, "reset_done", int'(done_a), 0);
    chk(tx_b == 1'b1, "reset_tx_b", int'(tx_b), 1);
    rst = 1'b1;
    repeat (3) step();

    // Basic frame, tick every clk.
    send(8'hA5, 160);

    // Tick every 8 clks, edge-case bytes.
    tick_period = 8;
    for (int i = 0; i < 4; i++) send(vec[i], 1280);
    tick_period = 1;
    repeat (4) step();

    // Request while busy is ignored.
    align();
    push(8'hA5, 160, 1'b0);
    tx_data = 8'hA5; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (40) step();
    tx_data = 8'h3C; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    wait_done(6000);
    repeat (30) step();

    // Back-to-back frames with tx_start held.
    align();
    push(8'h12, 160, 1'b0);
    push(8'h34, 160, 1'b1);
    tx_data = 8'h12; tx_start = 1'b1;
    step();
    wait_done(6000);
    tx_data = 8'h34;
    step();
    tx_start = 1'b0;
    wait_done(6000);
    step();

    // Asynchronous reset mid-DATA abandons the frame.
    align();
    tx_data = 8'hA5; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (40) step();
    #3 rst = 1'b0;
    #1;
    chk(tx_a == 1'b1, "async_rst_tx", int'(tx_a), 1);
    chk(busy_a == 1'b0, "async_rst_busy", int'(busy_a), 0);
    chk(done_a == 1'b0, "async_rst_done", int'(done_a), 0);
    repeat (3) @(posedge clk);
    #4 rst = 1'b1;
    repeat (3) step();
    send(8'h5A, 160);

    // Two stop bits, OVERSAMPLE 8, tick every 4 clks.
    sel = 1'b1;
    tick_period = 4;
    repeat (4) step();
    send(8'hC3, 352);

    // Same frame with a 50-clk tick stall inside a data bit.
    align();
    push(8'hC3, 402, 1'b0);
    tx_data = 8'hC3; tx_start = 1'b1;
    step();
    tx_start = 1'b0;
    repeat (99) step();
    stall = 1'b1;
    repeat (50) step();
    stall = 1'b0;
    wait_done(6000);

    repeat (50) step();
    chk(exp_q.size() == 0, "leftover_expected", exp_q.size(), 0);
    chk(done_cnt == 11, "done_count", done_cnt, 11);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
